centroid_tx: RTL and testbench

CENTROID_TX -- requirements
Module: centroid_tx

---
 rtl/centroid_tx.sv | 198 +++++++++++++++++++
 tb/tb_centroid_tx.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/centroid_tx.sv
// centroid_tx: accumulates masked pixel coordinates per frame, divides the
// sums by the pixel count and offers the (x,y) centroid on a valid/ready port.
//
// Ports:
//   clk, aresetn                   clock, async active-low reset
//   pix_valid, pix_sof, pix_mask   pixel stream in raster order
//   z_x, z_y, valid, ready         centroid output handshake
//   frame_drop                     1-cycle pulse when a finished frame is discarded
//
// Build option: CENTROID_HOLD_LAST_EN -- an empty frame re-offers the last centroid.
module centroid_tx #(
  parameter int DISP_WIDTH = 11,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic                  pix_valid,
  input  logic                  pix_sof,
  input  logic                  pix_mask,
  output logic [DISP_WIDTH-1:0] z_x,
  output logic [DISP_WIDTH-1:0] z_y,
  output logic                  valid,
  input  logic                  ready,
  output logic                  frame_drop
);

  localparam int SUM_W  = 3 * DISP_WIDTH;
  localparam int CNT_W  = 2 * DISP_WIDTH;
  localparam int STEP_W = $clog2(SUM_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    SEND
  } state_t;

  state_t state_q, state_d;

  logic [DISP_WIDTH-1:0] x_q, y_q;
  logic [DISP_WIDTH-1:0] cur_x, cur_y;
  logic                  line_end, last_line, eof;

  logic [SUM_W-1:0] sum_x, sum_y;
  logic [CNT_W-1:0] cnt;
  logic [SUM_W-1:0] nxt_sum_x, nxt_sum_y;
  logic [CNT_W-1:0] nxt_cnt;

  logic [SUM_W-1:0]  qx, qy;
  logic [CNT_W-1:0]  rx, ry;
  logic [CNT_W-1:0]  dv;
  logic [STEP_W-1:0] step;
  logic [SUM_W-1:0]  qx_n, qy_n;
  logic [CNT_W-1:0]  rx_n, ry_n;
  logic              start, div_last;

  // Position of the beat currently on the input; sof forces (0,0).
  assign cur_x     = pix_sof ? '0 : x_q;
  assign cur_y     = pix_sof ? '0 : y_q;
  assign line_end  = (cur_x == DISP_WIDTH'(H_ACTIVE - 1));
  assign last_line = (cur_y == DISP_WIDTH'(V_ACTIVE - 1));
  assign eof       = pix_valid & line_end & last_line;

  // sof restarts the frame, so its beat is added onto zero.
  always_comb begin
    nxt_sum_x = pix_sof ? '0 : sum_x;
    nxt_sum_y = pix_sof ? '0 : sum_y;
    nxt_cnt   = pix_sof ? '0 : cnt;
    if (pix_mask) begin
      nxt_sum_x = nxt_sum_x + SUM_W'(cur_x);
      nxt_sum_y = nxt_sum_y + SUM_W'(cur_y);
      nxt_cnt   = nxt_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      x_q   <= '0;
      y_q   <= '0;
      sum_x <= '0;
      sum_y <= '0;
      cnt   <= '0;
    end else if (pix_valid) begin
      if (line_end) begin
        x_q <= '0;
        y_q <= last_line ? '0 : cur_y + DISP_WIDTH'(1);
      end else begin
        x_q <= cur_x + DISP_WIDTH'(1);
        y_q <= cur_y;
      end
      if (eof) begin
        sum_x <= '0;
        sum_y <= '0;
        cnt   <= '0;
      end else begin
        sum_x <= nxt_sum_x;
        sum_y <= nxt_sum_y;
        cnt   <= nxt_cnt;
      end
    end
  end

  // One restoring-division step: returns {remainder, quotient}.
  function automatic logic [CNT_W+SUM_W-1:0] div_step(
    input logic [CNT_W-1:0] r,
    input logic [SUM_W-1:0] q,
    input logic [CNT_W-1:0] d
  );
    logic [CNT_W:0]   sh;
    logic [CNT_W+1:0] diff;
    sh   = {r, q[SUM_W-1]};
    diff = {1'b0, sh} - {2'b00, d};
    if (diff[CNT_W+1])
      div_step = {sh[CNT_W-1:0], q[SUM_W-2:0], 1'b0};
    else
      div_step = {diff[CNT_W-1:0], q[SUM_W-2:0], 1'b1};
  endfunction

  assign {rx_n, qx_n} = div_step(rx, qx, dv);
  assign {ry_n, qy_n} = div_step(ry, qy, dv);

  assign start    = (state_q == IDLE) && eof && (nxt_cnt != '0);
  assign div_last = (step == STEP_W'(SUM_W - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (eof) begin
          if (nxt_cnt != '0)
            state_d = DIV;
`ifdef CENTROID_HOLD_LAST_EN
          else
            state_d = SEND;
`endif
        end
      end
      DIV: begin
        if (div_last)
          state_d = SEND;
      end
      SEND: begin
        if (ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      qx   <= '0;
      qy   <= '0;
      rx   <= '0;
      ry   <= '0;
      dv   <= '0;
      step <= '0;
      z_x  <= '0;
      z_y  <= '0;
    end else if (start) begin
      qx   <= nxt_sum_x;
      qy   <= nxt_sum_y;
      rx   <= '0;
      ry   <= '0;
      dv   <= nxt_cnt;
      step <= '0;
    end else if (state_q == DIV) begin
      qx   <= qx_n;
      qy   <= qy_n;
      rx   <= rx_n;
      ry   <= ry_n;
      step <= step + STEP_W'(1);
      // z only changes here, so it holds the last result until then.
      if (div_last) begin
        z_x <= qx_n[DISP_WIDTH-1:0];
        z_y <= qy_n[DISP_WIDTH-1:0];
      end
    end
  end

  // A frame ending while a result is in flight is thrown away.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn)
      frame_drop <= 1'b0;
    else
      frame_drop <= eof && (state_q != IDLE);
  end

  assign valid = (state_q == SEND);

endmodule

// File: tb/tb_centroid_tx.sv
// tb_centroid_tx: directed frames with hand-computed centroids; a scoreboard
// queue is checked by an independent monitor on every valid/ready transfer.
module tb_centroid_tx;

  localparam int DW  = 11;
  localparam int H   = 16;
  localparam int V   = 24;
  localparam int LAT = 3 * 11 + 1;

  logic          clk = 1'b0;
  logic          aresetn = 1'b0;
  logic          pix_valid = 1'b0;
  logic          pix_sof = 1'b0;
  logic          pix_mask = 1'b0;
  logic          ready = 1'b1;
  logic [DW-1:0] z_x, z_y;
  logic          valid, frame_drop;

  centroid_tx #(
    .DISP_WIDTH(DW),
    .H_ACTIVE(H),
    .V_ACTIVE(V)
  ) dut (
    .clk(clk),
    .aresetn(aresetn),
    .pix_valid(pix_valid),
    .pix_sof(pix_sof),
    .pix_mask(pix_mask),
    .z_x(z_x),
    .z_y(z_y),
    .valid(valid),
    .ready(ready),
    .frame_drop(frame_drop)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int x;
    int y;
    int rise;
  } exp_t;

  exp_t sb[$];
  bit   mask_mem[V][H];
  int   n_checks = 0;
  int   n_fail = 0;
  int   drops = 0;
  int   rises = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  logic          v_prev = 1'b0;
  logic          acc_prev = 1'b0;
  logic          fd_prev = 1'b0;
  logic [DW-1:0] zx_prev = '0;
  logic [DW-1:0] zy_prev = '0;

  always @(negedge clk) begin
    if (!aresetn) begin
      v_prev   = 1'b0;
      acc_prev = 1'b0;
      fd_prev  = 1'b0;
    end else begin
      if (frame_drop) begin
        drops++;
        if (fd_prev) check("drop_width", 2, 1);
      end
      if (valid && !v_prev) begin
        rises++;
        if (sb.size() == 0)
          check("unexpected_valid", 1, 0);
        else if (sb[0].rise >= 0)
          check("valid_rise_cycle", cyc, sb[0].rise);
      end
      if (valid && v_prev && !acc_prev) begin
        check("z_x_hold", z_x, zx_prev);
        check("z_y_hold", z_y, zy_prev);
      end
      if (!valid && v_prev && !acc_prev)
        check("valid_dropped", 0, 1);
      if (valid && v_prev && acc_prev)
        check("valid_after_accept", 1, 0);
      if (valid && ready && sb.size() != 0) begin
        check("z_x", z_x, sb[0].x);
        check("z_y", z_y, sb[0].y);
        void'(sb.pop_front());
      end
      v_prev   = valid;
      acc_prev = valid && ready;
      fd_prev  = frame_drop;
      zx_prev  = z_x;
      zy_prev  = z_y;
    end
  end

  task automatic clear_mask();
    foreach (mask_mem[i, j]) mask_mem[i][j] = 1'b0;
  endtask

  task automatic send_beats(input int n, output int eoc);
    eoc = -1;
    for (int i = 0; i < n; i++) begin
      pix_valid = 1'b1;
      pix_sof   = (i == 0);
      pix_mask  = mask_mem[i / H][i % H];
      @(posedge clk);
      #1;
      if (i == H * V - 1) eoc = cyc;
    end
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    pix_mask  = 1'b0;
  endtask

  task automatic push_exp(input int x, input int y, input int rise);
    exp_t e;
    e.x = x;
    e.y = y;
    e.rise = rise;
    sb.push_back(e);
  endtask

  task automatic drain(input string name);
    int budget = 200;
    while (sb.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check(name, sb.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  int eoc;
  int d0;
  int r0;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_valid", valid, 0);
    check("rst_z_x", z_x, 0);
    check("rst_z_y", z_y, 0);
    check("rst_drop", frame_drop, 0);
    @(posedge clk);
    #1 aresetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // single pixel at (10,20)
    clear_mask();
    mask_mem[20][10] = 1'b1;
    send_beats(H * V, eoc);
    push_exp(10, 20, (eoc - 1) + LAT);
    drain("drain_single");

    // (0,0) and (3,5): floor(3/2), floor(5/2)
    clear_mask();
    mask_mem[0][0] = 1'b1;
    mask_mem[5][3] = 1'b1;
    send_beats(H * V, eoc);
    push_exp(1, 2, (eoc - 1) + LAT);
    drain("drain_floor");

    // restart after 5 mask pixels, then a lone pixel at (7,9)
    clear_mask();
    for (int i = 1; i <= 5; i++) mask_mem[0][i] = 1'b1;
    send_beats(40, eoc);
    clear_mask();
    mask_mem[9][7] = 1'b1;
    send_beats(H * V, eoc);
    push_exp(7, 9, (eoc - 1) + LAT);
    drain("drain_sof");

    // empty frame
    clear_mask();
    r0 = rises;
    send_beats(H * V, eoc);
`ifdef CENTROID_HOLD_LAST_EN
    push_exp(7, 9, eoc);
    drain("drain_hold_last");
    check("empty_rises", rises, r0 + 1);
`else
    repeat (LAT + 20) @(negedge clk);
    check("empty_rises", rises, r0);
`endif

    // backpressure across two frames
    ready = 1'b0;
    d0 = drops;
    clear_mask();
    mask_mem[6][4] = 1'b1;
    mask_mem[8][6] = 1'b1;
    send_beats(H * V, eoc);
    push_exp(5, 7, (eoc - 1) + LAT);
    clear_mask();
    mask_mem[1][1] = 1'b1;
    send_beats(H * V, eoc);
    repeat (3) @(negedge clk);
    check("drop_count", drops, d0 + 1);
    check("held_valid", valid, 1);
    check("held_z_x", z_x, 5);
    @(posedge clk);
    #1 ready = 1'b1;
    drain("drain_backpressure");

    // reset in the middle of the division
    d0 = drops;
    clear_mask();
    mask_mem[3][2] = 1'b1;
    send_beats(H * V, eoc);
    repeat (10) @(posedge clk);
    #1 aresetn = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", valid, 0);
    check("mid_rst_z_x", z_x, 0);
    check("mid_rst_z_y", z_y, 0);
    check("mid_rst_drop", frame_drop, 0);
    repeat (2) @(posedge clk);
    #1 aresetn = 1'b1;
    repeat (LAT + 5) @(negedge clk);
    check("post_rst_valid", valid, 0);
    check("post_rst_drops", drops, d0);
    @(posedge clk);
    #1;
    clear_mask();
    mask_mem[11][9]  = 1'b1;
    mask_mem[13][11] = 1'b1;
    send_beats(H * V, eoc);
    push_exp(10, 12, (eoc - 1) + LAT);
    drain("drain_after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
